uart_rx_param: RTL

Parametrised UART receive engine. Successor to the fixed 8-bit, 16x-oversampled receiver. Adds configurable frame format, majority-vote sampling, false-start rejection, parity/framing/overrun detection and a valid/ready output handshake. Sits between the shared baud-tick generator and the UART register/FIFO interface.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_rx_param.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal parameter ranges
// and the parity helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;

  // Expected parity bit for a zero-extended payload; odd=1 inverts it.
  function automatic logic parity_of(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the receiver: 2-flop synchroniser, falling-edge
// detect and a 3-tap majority vote over the last three baud ticks.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx_in,
  output logic line_s,
  output logic fall_edge,
  output logic vote
);

  logic [1:0] sync;
  logic       line_q;
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: everything resets to the idle level so reset release never looks like a start edge.
      sync   <= 2'b11;
      line_q <= 1'b1;
      hist   <= 2'b11;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
      sync   <= {sync[0], rx_in};
      line_q <= sync[1];
      if (baud_tick) hist <= {hist[0], sync[1]};
    end
  end

  assign line_s    = sync[1];
  assign fall_edge = line_q & ~line_s;
  // Taps are the two previous ticks plus the current one.
  assign vote      = (hist[1] & hist[0]) | (hist[1] & line_s) | (hist[0] & line_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receive engine: oversampled, majority-voted, with
// false-start rejection, parity/framing/overrun flags and valid/ready output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  // Start bit is judged mid-bit; every later sample is one full bit further.
  localparam logic [TW-1:0] START_TGT = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] BIT_TGT   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  uart_rx_state_t state, state_next;

  logic                 line_s, fall_edge, vote;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, frame_bad;
  logic                 last_tick, take, complete;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx_in     (rx_in),
    .line_s    (line_s),
    .fall_edge (fall_edge),
    .vote      (vote)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_next = state;
    take       = 1'b0;
    complete   = 1'b0;
    last_tick  = baud_tick && (tick_cnt == ((state == START) ? START_TGT : BIT_TGT));
    case (state)
      IDLE: if (en && fall_edge && !line_s) state_next = START;
      START: begin
        if (last_tick) begin
          take       = 1'b1;
          state_next = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last_tick) begin
          take = 1'b1;
          if (bit_cnt == DATA_LAST) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last_tick) begin
          take       = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (last_tick) begin
          take = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            state_next = IDLE;
            complete   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bad     <= 1'b0;
      frame_bad   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (state_next != state) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (baud_tick && state != IDLE) begin
        if (take) begin
          tick_cnt <= '0;
          bit_cnt  <= bit_cnt + BW'(1);
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end

      if (state == IDLE && state_next == START) begin
        par_bad   <= 1'b0;
        frame_bad <= 1'b0;
      end

      if (take) begin
        case (state)
          DATA:    shreg <= {vote, shreg[DATA_BITS-1:1]};
          PARITY:  par_bad <= vote ^ parity_of(16'(shreg), PARITY_ODD != 0);
          STOP:    if (!vote) frame_bad <= 1'b1;
          default: ;
        endcase
      end

      // A completing frame may load in the same cycle the held word is taken.
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_bad;
          frame_err  <= frame_bad | ~vote;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule
